// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
// Holds the sequencer state encoding, BCD digit type and entry clamp limits.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_SEC = 3'd1,
    RUN     = 3'd2,
    PAUSE   = 3'd3,
    ALARM   = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_ONES     = 4'd9;
  localparam bcd_t MAX_SEC_TENS = 4'd5;

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit BCD mm:ss register with clamped entry loads and a borrow-chain decrement.
// Decrement saturates at 00:00; zero/last flag the current and next-to-zero time.
module bcd_mmss_counter
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_min,
  input  logic       load_sec,
  input  logic       dec,
  input  logic [7:0] sw,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       zero,
  output logic       last
);

  assign zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign last = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // Digit registers: loads take priority; decrement borrows ones -> tens -> minutes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (load_min) begin
      min_tens <= clamp_digit(sw[7:4], MAX_ONES);
      min_ones <= clamp_digit(sw[3:0], MAX_ONES);
    end else if (load_sec) begin
      sec_tens <= clamp_digit(sw[7:4], MAX_SEC_TENS);
      sec_ones <= clamp_digit(sw[3:0], MAX_ONES);
    end else if (dec && !zero) begin
      if (sec_ones != 4'd0) begin
        sec_ones <= sec_ones - 4'd1;
      end else begin
        sec_ones <= MAX_ONES;
        if (sec_tens != 4'd0) begin
          sec_tens <= sec_tens - 4'd1;
        end else begin
          sec_tens <= MAX_SEC_TENS;
          if (min_ones != 4'd0) begin
            min_ones <= min_ones - 4'd1;
          end else begin
            // Not zero with all lower digits at 0 means min_tens is non-zero.
            min_ones <= MAX_ONES;
            min_tens <= min_tens - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Egg-timer sequencer: entry, start/pause/resume, 1 Hz tick, countdown and timed alarm.
// All status outputs are registered; time digits come straight from the BCD register.
module countdown_sequencer
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int FLASH_DIV  = 25000000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_p,
  input  logic       start_stop_p,
  input  logic [7:0] sw,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       entry_sec,
  output logic       flash_on
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_ONE   = TICK_W'(1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_ONE  = FLASH_W'(1);
  localparam logic [7:0]         ALARM_LAST = 8'(ALARM_SECS - 1);

  state_t               state_r;
  logic [TICK_W-1:0]    tick_r;
  logic [FLASH_W-1:0]   flash_cnt_r;
  logic [7:0]           alarm_cnt_r;

  logic load_min_s;
  logic load_sec_s;
  logic dec_s;
  logic tick_wrap_s;
  logic to_idle_s;
  logic time_zero_s;
  logic time_last_s;

  bcd_mmss_counter u_time (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_min (load_min_s),
    .load_sec (load_sec_s),
    .dec      (dec_s),
    .sw       (sw),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .zero     (time_zero_s),
    .last     (time_last_s)
  );

  // Per-state strobes to the digit register and the common return-to-IDLE condition.
  always_comb begin
    load_min_s  = 1'b0;
    load_sec_s  = 1'b0;
    dec_s       = 1'b0;
    to_idle_s   = 1'b0;
    tick_wrap_s = (tick_r == TICK_LAST);
    case (state_r)
      IDLE:    load_min_s = set_p;
      SET_SEC: begin
        load_sec_s = set_p;
        to_idle_s  = set_p;
      end
      RUN: begin
        to_idle_s = set_p;
        dec_s     = !set_p && !start_stop_p && tick_wrap_s;
      end
      PAUSE:   to_idle_s = set_p;
      ALARM:   to_idle_s = set_p || start_stop_p ||
                           (tick_wrap_s && (alarm_cnt_r == ALARM_LAST));
      default: to_idle_s = 1'b1;
    endcase
  end

  // Sequencer FSM with tick divider, flash divider and alarm-second counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      tick_r      <= '0;
      flash_cnt_r <= '0;
      alarm_cnt_r <= 8'd0;
      running     <= 1'b0;
      entry_sec   <= 1'b0;
      flash_on    <= 1'b0;
    end else if (to_idle_s) begin
      state_r     <= IDLE;
      tick_r      <= '0;
      flash_cnt_r <= '0;
      alarm_cnt_r <= 8'd0;
      running     <= 1'b0;
      entry_sec   <= 1'b0;
      flash_on    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (set_p) begin
            state_r   <= SET_SEC;
            entry_sec <= 1'b1;
          end else if (start_stop_p && !time_zero_s) begin
            state_r <= RUN;
            running <= 1'b1;
            tick_r  <= '0;
          end
        end
        SET_SEC: entry_sec <= 1'b1;
        RUN: begin
          if (start_stop_p) begin
            state_r <= PAUSE;
            running <= 1'b0;
          end else if (tick_wrap_s) begin
            tick_r <= '0;
            if (time_last_s) begin
              state_r     <= ALARM;
              running     <= 1'b0;
              flash_on    <= 1'b1;
              flash_cnt_r <= '0;
              alarm_cnt_r <= 8'd0;
            end
          end else begin
            tick_r <= tick_r + TICK_ONE;
          end
        end
        PAUSE: begin
          // Tick count is held so a resume continues the interrupted second.
          if (start_stop_p) begin
            state_r <= RUN;
            running <= 1'b1;
          end
        end
        ALARM: begin
          if (flash_cnt_r == FLASH_LAST) begin
            flash_cnt_r <= '0;
            flash_on    <= !flash_on;
          end else begin
            flash_cnt_r <= flash_cnt_r + FLASH_ONE;
          end
          if (tick_wrap_s) begin
            tick_r      <= '0;
            alarm_cnt_r <= alarm_cnt_r + 8'd1;
          end else begin
            tick_r <= tick_r + TICK_ONE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with TICK_DIV=4, FLASH_DIV=2, ALARM_SECS=3.
module tb_countdown_sequencer;

  logic       clk;
  logic       reset_n;
  logic       set_p;
  logic       start_stop_p;
  logic [7:0] sw;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, entry_sec, flash_on;

  int checks = 0;
  int errors = 0;

  countdown_sequencer #(
    .TICK_DIV   (4),
    .FLASH_DIV  (2),
    .ALARM_SECS (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .set_p        (set_p),
    .start_stop_p (start_stop_p),
    .sw           (sw),
    .sec_ones     (sec_ones),
    .sec_tens     (sec_tens),
    .min_ones     (min_ones),
    .min_tens     (min_tens),
    .running      (running),
    .entry_sec    (entry_sec),
    .flash_on     (flash_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        ss;
    logic [7:0]  w;
    logic [15:0] t;
    logic        run;
    logic        ent;
    logic        fl;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic expect_all(input string name, input logic [15:0] t, input logic run,
                            input logic ent, input logic fl);
    check({name, ".time"}, {16'h0, min_tens, min_ones, sec_tens, sec_ones}, {16'h0, t});
    check({name, ".running"}, {31'h0, running}, {31'h0, run});
    check({name, ".entry_sec"}, {31'h0, entry_sec}, {31'h0, ent});
    check({name, ".flash_on"}, {31'h0, flash_on}, {31'h0, fl});
  endtask

  // One clock with the given pulses; returns 1 time unit after the edge.
  task automatic step(input logic s, input logic ss, input logic [7:0] w);
    set_p        = s;
    start_stop_p = ss;
    sw           = w;
    @(posedge clk);
    #1;
    set_p        = 1'b0;
    start_stop_p = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0}; // start at 00:00 ignored
    vecs[1] = '{1'b1, 1'b1, 8'h7C, 16'h7900, 1'b0, 1'b1, 1'b0}; // set wins, ones clamp
    vecs[2] = '{1'b0, 1'b1, 8'h00, 16'h7900, 1'b0, 1'b1, 1'b0}; // start ignored in SET_SEC
    vecs[3] = '{1'b0, 1'b0, 8'h00, 16'h7900, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h9A, 16'h7959, 1'b0, 1'b0, 1'b0}; // sec tens 9->5, ones A->9
    vecs[5] = '{1'b1, 1'b0, 8'hA3, 16'h9359, 1'b0, 1'b1, 1'b0}; // min tens A->9
    vecs[6] = '{1'b1, 1'b0, 8'h05, 16'h9305, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h01, 16'h0105, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 16'h0100, 1'b0, 1'b0, 1'b0};

    reset_n      = 1'b0;
    set_p        = 1'b0;
    start_stop_p = 1'b0;
    sw           = 8'h00;
    #2;
    expect_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].s, vecs[i].ss, vecs[i].w);
      expect_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].run, vecs[i].ent, vecs[i].fl);
    end

    // Countdown from 01:00 into ALARM, then the flash pattern and auto-return.
    step(1'b0, 1'b1, 8'h00);
    expect_all("start", 16'h0100, 1'b1, 1'b0, 1'b0);
    idle(3);
    expect_all("pre_first_tick", 16'h0100, 1'b1, 1'b0, 1'b0);
    idle(1);
    expect_all("first_tick", 16'h0059, 1'b1, 1'b0, 1'b0);
    idle(232);
    expect_all("at_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
    idle(3);
    expect_all("hold_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
    idle(1);
    expect_all("alarm_entry", 16'h0000, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      idle(1);
      expect_all($sformatf("alarm_k%0d", k), 16'h0000, 1'b0, 1'b0,
                 (k < 12) ? (((k / 2) % 2) == 0) : 1'b0);
    end

    // Alarm aborted by start_stop_p.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h01);
    expect_all("load_0001", 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    idle(4);
    expect_all("alarm2_entry", 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_all("alarm2_k1", 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00);
    expect_all("alarm_abort", 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00);
    expect_all("abort_is_idle", 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h05);
    expect_all("load_0005", 16'h0005, 1'b0, 1'b0, 1'b0);

    // Pause and resume keep the partial second.
    step(1'b0, 1'b1, 8'h00);
    idle(2);
    step(1'b0, 1'b1, 8'h00);
    expect_all("pause", 16'h0005, 1'b0, 1'b0, 1'b0);
    idle(20);
    expect_all("paused_hold", 16'h0005, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    expect_all("resume", 16'h0005, 1'b1, 1'b0, 1'b0);
    idle(1);
    expect_all("resume_1", 16'h0005, 1'b1, 1'b0, 1'b0);
    idle(1);
    expect_all("resume_2", 16'h0004, 1'b1, 1'b0, 1'b0);

    // set_p in RUN keeps time and clears the tick count.
    step(1'b1, 1'b0, 8'h99);
    expect_all("run_set_idle", 16'h0004, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    idle(3);
    expect_all("restart_hold", 16'h0004, 1'b1, 1'b0, 1'b0);
    idle(1);
    expect_all("restart_tick", 16'h0003, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges while running.
    idle(1);
    #3;
    reset_n = 1'b0;
    #1;
    expect_all("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    step(1'b0, 1'b1, 8'h00);
    expect_all("after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
